// File: rtl/sub32_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sub32_sequencer
// Description : Two-port round-robin 32-bit subtractor built on one shared
//               8-bit subtract slice, processing bytes LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module sub32_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic [1:0]  req_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_port,
    output logic [31:0] res_d,
    output logic        res_bout,
    output logic        res_ovf,
    output logic        busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  w_grant;
    logic [1:0]  r_cnt;
    logic        r_brw;
    logic        r_ptr;
    logic        r_port;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_d;
    logic [7:0]  w_a_byte;
    logic [7:0]  w_b_byte;
    logic [7:0]  w_slice_d;
    logic        w_slice_bout;

    // The single shared byte slice; bit 8 of the 9-bit difference is the borrow.
    assign w_a_byte = r_a[{r_cnt, 3'b000} +: 8];
    assign w_b_byte = r_b[{r_cnt, 3'b000} +: 8];
    assign {w_slice_bout, w_slice_d} = {1'b0, w_a_byte} - {1'b0, w_b_byte} - {8'd0, r_brw};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 2'b00;
        case (r_state)
            c_IDLE: begin
                // r_ptr holds the last-granted port, so a tie goes to the other one.
                if (req_valid == 2'b11) begin
                    w_grant = r_ptr ? 2'b01 : 2'b10;
                end else begin
                    w_grant = req_valid;
                end
                if (rst) begin
                    w_grant = 2'b00;
                end
                if (w_grant != 2'b00) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (r_cnt == 2'd3) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                if (res_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_brw  <= 1'b0;
            r_ptr  <= 1'b1;
            r_port <= 1'b0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_d    <= 32'd0;
        end else begin
            if (r_state == c_IDLE && w_grant != 2'b00) begin
                r_port <= w_grant[1];
                r_ptr  <= w_grant[1];
                r_a    <= w_grant[1] ? req_a1 : req_a0;
                r_b    <= w_grant[1] ? req_b1 : req_b0;
                r_cnt  <= 2'd0;
                r_brw  <= 1'b0;
            end else if (r_state == c_RUN) begin
                r_d[{r_cnt, 3'b000} +: 8] <= w_slice_d;
                r_brw <= w_slice_bout;
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    // Outputs are forced low while reset is asserted, not just after the edge.
    assign req_ready = w_grant;
    assign busy      = !rst && (r_state != c_IDLE);
    assign res_valid = !rst && (r_state == c_DONE);
    assign res_port  = !rst && r_port;
    assign res_d     = rst ? 32'd0 : r_d;
    assign res_bout  = !rst && r_brw;
    assign res_ovf   = !rst && (r_a[31] != r_b[31]) && (r_d[31] != r_a[31]);

endmodule
`default_nettype wire

// File: tb/tb_sub32_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub32_sequencer
// Description : Directed, table-driven bench for sub32_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub32_sequencer;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic        res_port;
    logic [31:0] res_d;
    logic        res_bout;
    logic        res_ovf;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    sub32_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_port  (res_port),
        .res_d     (res_d),
        .res_bout  (res_bout),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Full transaction: request, grant, 5-cycle latency, result check, consume.
    task automatic issue(input logic p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic bo, input logic ov);
        int cyc;
        int lat;
        @(negedge clk);
        if (p) begin
            req_a1 = a;
            req_b1 = b;
        end else begin
            req_a0 = a;
            req_b0 = b;
        end
        req_valid = p ? 2'b10 : 2'b01;
        #1;
        cyc = 0;
        while (req_ready == 2'b00 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("grant", {30'd0, req_ready}, p ? 32'd2 : 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        req_a0 = $urandom;
        req_b0 = $urandom;
        req_a1 = $urandom;
        req_b1 = $urandom;
        #1;
        lat = 1;
        while (!res_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", lat, 32'd5);
        chk("res_d", res_d, d);
        chk("res_bout", {31'd0, res_bout}, {31'd0, bo});
        chk("res_ovf", {31'd0, res_ovf}, {31'd0, ov});
        chk("res_port", {31'd0, res_port}, {31'd0, p});
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("idle_after_consume", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int nv;
        vecs[0] = '{1'b0, 32'd255,        32'd15,         32'h000000F0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'd10,         32'd50,         32'hFFFFFFD8, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h00000100,   32'd1,          32'h000000FF, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h80000000,   32'd1,          32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 32'd0,          32'd1,          32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000000, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 32'h12345678,   32'h12345678,   32'h00000000, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h00010000,   32'd1,          32'h0000FFFF, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'h80000000,   32'h7FFFFFFF, 1'b0, 1'b0};

        rst = 1'b1;
        req_valid = 2'b00;
        res_ready = 1'b0;
        req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
        repeat (2) @(negedge clk);

        // Reset state, with both requests already pending.
        req_valid = 2'b11;
        req_a0 = 32'd15; req_b0 = 32'd15;
        req_a1 = 32'd21; req_b1 = 32'd15;
        #1;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_d", res_d, 32'd0);
        chk("rst_flags", {29'd0, res_port, res_bout, res_ovf}, 32'd0);

        // Tie from reset: port 0 first, port 1 in the IDLE cycle after consumption.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("tie_first_grant", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_req_ready", {30'd0, req_ready}, 32'd0);
        repeat (4) step();
        chk("tie0_valid", {31'd0, res_valid}, 32'd1);
        chk("tie0_res_d", res_d, 32'd0);
        chk("tie0_port", {31'd0, res_port}, 32'd0);
        chk("done_req_ready", {30'd0, req_ready}, 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("tie_second_grant", {30'd0, req_ready}, 32'd2);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        repeat (4) step();
        chk("tie1_valid", {31'd0, res_valid}, 32'd1);
        chk("tie1_res_d", res_d, 32'd6);
        chk("tie1_port", {31'd0, res_port}, 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Back-pressure: 10 cycles in DONE with a pending request.
        @(negedge clk);
        req_a0 = 32'd100; req_b0 = 32'd1;
        req_valid = 2'b01;
        #1;
        chk("bp_grant", {30'd0, req_ready}, 32'd1);
        repeat (5) step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_res_d", res_d, 32'd99);
            chk("bp_port", {31'd0, res_port}, 32'd0);
            chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
            step();
        end
        @(negedge clk);
        res_ready = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("bp_idle", {31'd0, busy}, 32'd0);

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        req_a0 = 32'd55; req_b0 = 32'd39;
        req_valid = 2'b01;
        #1;
        chk("ro_grant", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ro_busy", {31'd0, busy}, 32'd0);
        chk("ro_valid", {31'd0, res_valid}, 32'd0);
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_valid) nv++;
            step();
        end
        chk("ro_no_pulse", nv, 32'd0);
        issue(1'b0, 32'd55, 32'd39, 32'h00000010, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bout, vecs[i].ovf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sub32_sequencer.md
SUB32_SEQUENCER -- requirements
Module: sub32_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 req_valid  input  2  per-port request; bit p belongs to port p.
REQ-005 req_a0, req_b0  input  32 each  port-0 minuend and subtrahend.
REQ-006 req_a1, req_b1  input  32 each  port-1 minuend and subtrahend.
REQ-007 req_ready  output  2  one-hot grant or acknowledge; high for one cycle on the accepted port.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  result consumer accepts.
REQ-010 res_port  output  1  port index that owns the current result.
REQ-011 res_d  output  32  difference A-B, modulo 2^32.
REQ-012 res_bout  output  1  final borrow; 1 when A<B unsigned.
REQ-013 res_ovf  output  1  two's-complement signed overflow of A-B.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The block SHALL contain exactly one 8-bit subtract slice computing {bout, d} = a - b - bin, shared across all bytes and both ports.
REQ-016 The state machine SHALL have the states IDLE, RUN and DONE, plus a 2-bit byte counter cnt and a borrow register brw.
REQ-017 IDLE: if any req_valid is high, the block SHALL grant one port by round-robin, assert req_ready for that port for that cycle only, latch the port's A, B and index, clear cnt and brw, and go to RUN.
REQ-018 Round-robin: the port other than the last-granted one SHALL win when both requests are valid; a lone request SHALL win regardless of the pointer; the pointer SHALL update only on a grant.
REQ-019 RUN, per cycle: the slice SHALL operate on byte cnt (A[8cnt+7:8cnt], B[8cnt+7:8cnt], bin=brw); result byte cnt <= d; brw <= bout; cnt <= cnt+1.
REQ-020 RUN with cnt==3: the block SHALL go to DONE after the update.
REQ-021 Bytes SHALL be processed LSB first, so the borrow ripples byte 0 to byte 3.
REQ-022 DONE: res_valid SHALL be 1, and res_d, res_bout (=brw), res_ovf and res_port SHALL be held stable.
REQ-023 DONE with res_ready=1: the result SHALL be consumed that cycle and the block SHALL go to IDLE; no grant occurs in that same cycle.
REQ-024 DONE with res_ready=0: the block SHALL remain in DONE indefinitely with all outputs unchanged.
REQ-025 res_ovf SHALL equal (A[31] != B[31]) AND (res_d[31] != A[31]), using the latched operands.
REQ-026 Latency: if req_ready is high in cycle t, RUN SHALL occupy cycles t+1 to t+4 and res_valid SHALL first be high in cycle t+5.
REQ-027 Minimum issue interval SHALL be 6 cycles.
REQ-028 req_ready SHALL be 0 in RUN and DONE; a requester holds req_valid and its operands until acknowledged.
REQ-029 Operand changes on the input ports after the grant SHALL NOT affect the in-flight result.
REQ-030 res_valid and req_ready SHALL never be high in the same cycle.

Reset
REQ-031 rst=1 SHALL force, at the next edge: state=IDLE, cnt=0, brw=0, pointer=1 (port 0 wins the first tie).
REQ-032 rst=1 SHALL drive req_ready=0, res_valid=0, res_d=0, res_bout=0, res_ovf=0, res_port=0 and busy=0.
REQ-033 Reset asserted in RUN or DONE SHALL discard the in-flight operation with no res_valid pulse.
REQ-034 The first grant after reset SHALL be no earlier than the cycle after rst deasserts.

Verification
REQ-035 Port 0, A=255, B=15, res_ready=1 -> res_d=0x000000F0, bout=0, ovf=0, res_valid in cycle t+5.
REQ-036 Port 1, A=10, B=50 -> res_d=0xFFFFFFD8, bout=1, ovf=0, res_port=1.
REQ-037 A=0x00000100, B=1 (borrow ripple into byte 1) -> res_d=0x000000FF, bout=0; A=0x80000000, B=1 -> res_d=0x7FFFFFFF, ovf=1.
REQ-038 Both ports valid from reset (port 0: A=15, B=15; port 1: A=21, B=15) -> port 0 granted first with res_d=0; port 1 granted in the IDLE cycle after consumption with res_d=6.
REQ-039 Back-pressure: hold res_ready=0 for 10 cycles in DONE -> res_valid, res_d and res_port stay stable and req_ready stays 0; then res_ready=1 for one cycle -> IDLE.
REQ-040 Reset mid-operation: assert rst in the 2nd RUN cycle of A=55, B=39 -> next cycle busy=0 and res_valid=0; re-issue -> res_d=0x00000010.
